spi_req_queue: RTL and testbench

Request-queue front end for the SPI master interface block. Accepts write/read commands over a valid/ready port, buffers them in a small FIFO, launches them one at a time on the SPI master, and returns one response per command (read data, error flag) over a second valid/ready port. The SPI master starts a transaction whenever it is out of reset, so this block gates it through `m_rst` and holds its command inputs stable for the full transaction.

---
 rtl/spi_req_pkg.sv | 19 +
 rtl/spi_req_fifo.sv | 60 ++++++
 rtl/spi_req_queue.sv | 145 ++++++++++++++
 tb/tb_spi_req_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_req_pkg.sv
// Shared types for the SPI request queue: controller states, queued command word, memory size.
// Pure declarations, no logic.
package spi_req_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } spi_req_state_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } spi_req_t;

    localparam int SPI_MEM_WORDS = 32;

endpackage

// File: rtl/spi_req_fifo.sv
// Synchronous FIFO of spi_req_t commands; head visible combinationally, flushed by rst.
// Push ignored when full, pop ignored when empty; a same-cycle pop does not make room for a push.
import spi_req_pkg::*;

module spi_req_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  spi_req_t               push_dat,
    input  logic                   pop,
    output spi_req_t               pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    spi_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_req_queue.sv
// Queues SPI commands, runs them one at a time on the master (held in m_rst between runs), returns one response each.
// Push-to-launch 2 cycles; response the cycle after m_done; no new launch while a response is held.
// SPI_REQ_TIMEOUT_EN adds a WAIT_DONE timeout of TIMEOUT cycles reported via rsp_err/rsp_timeout.
import spi_req_pkg::*;

module spi_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] rsp_addr,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       m_rst,
    output logic       m_wr,
    output logic [7:0] m_addr,
    output logic [7:0] m_din,
    input  logic [7:0] m_dout,
    input  logic       m_done,
    input  logic       m_err
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_chk
        $error("spi_req_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    spi_req_state_t   state;
    spi_req_t         push_req;
    spi_req_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CNT_W-1:0] fifo_count;

    assign push_req  = '{wr: req_wr, addr: req_addr, data: req_data};
    assign req_ready = ~rst & (fifo_count != CNT_W'(DEPTH));
    assign fifo_pop  = (state == IDLE) & ~fifo_empty & ~rsp_valid;

    spi_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_valid & ~fifo_full),
        .push_dat (push_req),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef SPI_REQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    logic [TMR_W-1:0] timer;
    logic             expired;

    assign expired = (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state == LAUNCH) begin
            timer <= '0;
        end else if (state == WAIT_DONE && !m_done && timer != '1) begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_addr  <= 8'h00;
            rsp_err   <= 1'b0;
`ifdef SPI_REQ_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            m_rst     <= 1'b1;
            m_wr      <= 1'b0;
            m_addr    <= 8'h00;
            m_din     <= 8'h00;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    m_rst <= 1'b1;
                    if (fifo_pop) begin
                        m_wr   <= head.wr;
                        m_addr <= head.addr;
                        m_din  <= head.data;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    m_rst <= 1'b0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // m_done beats a simultaneous timeout expiry
                    if (m_done) begin
                        rsp_data  <= m_wr ? 8'h00 : m_dout;
                        rsp_addr  <= m_addr;
                        rsp_err   <= m_err;
`ifdef SPI_REQ_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                        rsp_valid <= 1'b1;
                        m_rst     <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef SPI_REQ_TIMEOUT_EN
                    else if (expired) begin
                        rsp_data    <= 8'h00;
                        rsp_addr    <= m_addr;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        m_rst       <= 1'b1;
                        state       <= IDLE;
                    end
`endif
                end
                default: begin
                    m_rst <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_queue.sv
// Randomized bench for spi_req_queue: behavioural SPI device plus in-order response scoreboard.
// Timeout scenario is exercised only when SPI_REQ_TIMEOUT_EN is defined.
module tb_spi_req_queue;
    import spi_req_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_wr;
    logic [7:0] req_addr, req_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data, rsp_addr;
    logic       rsp_err, rsp_timeout;
    logic       m_rst, m_wr;
    logic [7:0] m_addr, m_din, m_dout;
    logic       m_done, m_err;

    always #5 clk = ~clk;

    spi_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_rst(m_rst), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din),
        .m_dout(m_dout), .m_done(m_done), .m_err(m_err)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] data;
        logic       err;
        logic       to;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem[SPI_MEM_WORDS];
    logic [7:0] dev_mem[SPI_MEM_WORDS];
    int         n_chk = 0;
    int         n_err = 0;
    bit         hang = 1'b0;
    int         rdy_mode = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected outcome of an accepted command, from the command stream alone
    function automatic void model_push(input logic wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.wr = wr; e.addr = a; e.din = d; e.data = 8'h00; e.err = 1'b0; e.to = 1'b0;
        if (hang) begin
            e.err = 1'b1; e.to = 1'b1;
        end else if (a >= SPI_MEM_WORDS) begin
            e.err = 1'b1;
        end else if (wr) begin
            model_mem[a[4:0]] = d;
        end else begin
            e.data = model_mem[a[4:0]];
        end
        exp_q.push_back(e);
    endfunction

    task automatic master();
        bit busy = 1'b0;
        int lat = 0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0; m_err = 1'b0; m_dout = 8'($urandom);
            if (m_rst) begin
                busy = 1'b0;
            end else if (!busy) begin
                busy = 1'b1;
                lat = $urandom_range(0, 5);
            end else if (lat > 0) begin
                lat--;
            end else if (!hang) begin
                m_done = 1'b1;
                busy = 1'b0;
                if (m_addr >= SPI_MEM_WORDS) begin
                    m_err = 1'b1;
                    if (!m_wr) m_dout = 8'h00;
                end else if (m_wr) begin
                    dev_mem[m_addr[4:0]] = m_din;
                end else begin
                    m_dout = dev_mem[m_addr[4:0]];
                end
            end
        end
    endtask

    task automatic rdy_drv();
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic monitor();
        exp_t       e;
        bit         mlow_q = 1'b0;
        bit         held_q = 1'b0;
        int         low_len = 0;
        logic       mw_q = 1'b0, re_q = 1'b0, rt_q = 1'b0;
        logic [7:0] ma_q = 8'h00, md_q = 8'h00, rd_q = 8'h00, ra_q = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                mlow_q = 1'b0; held_q = 1'b0; low_len = 0;
                continue;
            end
            if (req_valid && req_ready) model_push(req_wr, req_addr, req_data);
            if (!m_rst) begin
                if (mlow_q) begin
                    chk("m_wr_stable", m_wr, mw_q);
                    chk("m_addr_stable", m_addr, ma_q);
                    chk("m_din_stable", m_din, md_q);
                end else if (exp_q.size() == 0) begin
                    chk("launch_without_cmd", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("launch_wr", m_wr, e.wr);
                    chk("launch_addr", m_addr, e.addr);
                    if (e.wr) chk("launch_din", m_din, e.din);
                end
                low_len++;
            end else if (mlow_q) begin
`ifdef SPI_REQ_TIMEOUT_EN
                if (hang) chk("timeout_len", low_len, TIMEOUT);
`endif
                low_len = 0;
            end
            if (rsp_valid) chk("m_rst_while_rsp_held", m_rst, 1);
            if (held_q) begin
                chk("rsp_valid_held", rsp_valid, 1);
                chk("rsp_data_held", rsp_data, rd_q);
                chk("rsp_addr_held", rsp_addr, ra_q);
                chk("rsp_err_held", rsp_err, re_q);
                chk("rsp_timeout_held", rsp_timeout, rt_q);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_addr", rsp_addr, e.addr);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_timeout", rsp_timeout, e.to);
                end
            end
            held_q = rsp_valid && !rsp_ready;
            rd_q = rsp_data; ra_q = rsp_addr; re_q = rsp_err; rt_q = rsp_timeout;
            mlow_q = !m_rst; mw_q = m_wr; ma_q = m_addr; md_q = m_din;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the push edge
    task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        req_wr = wr; req_addr = a; req_data = d; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("send_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int   n;
        logic quiet;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_data = 8'h00;
        rsp_ready = 1'b1; m_done = 1'b0; m_err = 1'b0; m_dout = 8'h00;
        for (int i = 0; i < SPI_MEM_WORDS; i++) begin
            model_mem[i] = 8'h00;
            dev_mem[i] = 8'h00;
        end
        fork
            monitor();
            master();
            rdy_drv();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("req_ready_in_reset", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_m_rst", m_rst, 1);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_din", m_din, 0);
        @(posedge clk); #1;

        // Write then read back, out-of-range read, then a normal read
        send(1'b1, 8'd5, 8'hA5);
        send(1'b0, 8'd5, 8'h00);
        send(1'b0, 8'd40, 8'h00);
        send(1'b0, 8'd5, 8'h00);
        wait_drain();

        // Backpressure: one held response plus DEPTH queued, sixth refused
        rdy_mode = 0;
        idle(2);
        for (int i = 0; i < 5; i++) send(1'b1, 8'(10 + i), 8'($urandom));
        req_wr = 1'b0; req_addr = 8'd10; req_data = 8'h00; req_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("sixth_refused", req_ready, 0);
        chk("rsp_held_valid", rsp_valid, 1);
        chk("accepted_count", exp_q.size(), 5);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdy_mode = 1;
        wait_drain();

        // Sequential writes and read-back with continuous rsp_ready
        for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 8'(8'h30 + i));
        for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 8'h00);
        wait_drain();

        // Random traffic with random response backpressure
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 47)), 8'($urandom));
            idle($urandom_range(0, 3));
        end
        rdy_mode = 1;
        wait_drain();

`ifdef SPI_REQ_TIMEOUT_EN
        hang = 1'b1;
        send(1'b0, 8'd3, 8'h00);
        wait_drain();
        hang = 1'b0;
        send(1'b0, 8'd5, 8'h00);
        wait_drain();
`endif

        // Reset while a transaction is in WAIT_DONE with two more queued
        hang = 1'b1;
        send(1'b0, 8'd1, 8'h00);
        send(1'b0, 8'd2, 8'h00);
        send(1'b0, 8'd3, 8'h00);
        n = 0;
        @(negedge clk);
        while (m_rst && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait_done", m_rst, 0);
        idle(3);
        rst = 1'b1;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_m_rst", m_rst, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || !m_rst) quiet = 1'b0;
        end
        chk("post_rst_fifo_empty", quiet, 1);
        @(posedge clk); #1;
        send(1'b0, 8'd5, 8'h00);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
